// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: opcodes, error codes
// and the bit offsets of the fields inside one packed program slot.
package isa_pkg;

  localparam int OP_NOP = 0;
  localparam int OP_LD  = 1;
  localparam int OP_STR = 2;
  localparam int OP_BRA = 3;
  localparam int OP_XOR = 4;
  localparam int OP_ADD = 5;
  localparam int OP_ROT = 6;
  localparam int OP_SHF = 7;
  localparam int OP_HLT = 8;
  localparam int OP_CMP = 9;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_OVERRUN    = 2'd1,
    ERR_BAD_TARGET = 2'd2,
    ERR_WATCHDOG   = 2'd3
  } err_e;

  // Slot layout, LSB first: lit, src, dst, op.
  function automatic int lit_lsb();
    return 0;
  endfunction

  function automatic int src_lsb();
    return 1;
  endfunction

  function automatic int dst_lsb(input int busw);
    return busw + 1;
  endfunction

  function automatic int op_lsb(input int busw);
    return 2 * busw + 1;
  endfunction

  function automatic int slot_bits(input int opw, input int busw);
    return opw + 2 * busw + 1;
  endfunction

endpackage

// File: rtl/instr_slot_decode.sv
// Picks program slot pc out of a packed program image and splits it into
// op/dst/src/lit. Slots past the end of the program read as all zero.
module instr_slot_decode
  import isa_pkg::*;
#(
  parameter int BUSW    = 32,
  parameter int OPW     = 4,
  parameter int PROGLEN = 8,
  parameter int PLLEN   = OPW + 2 * BUSW + 1,
  parameter int PCW     = $clog2(PROGLEN + 1)
) (
  input  logic [PLLEN*PROGLEN-1:0] image,
  input  logic [PCW-1:0]           pc,
  output logic [OPW-1:0]           op,
  output logic [BUSW-1:0]          dst,
  output logic [BUSW-1:0]          src,
  output logic                     lit
);

  logic [PLLEN-1:0] slot;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot = '0;
    if (pc < PCW'(PROGLEN)) slot = image[int'(pc) * PLLEN +: PLLEN];
  end

  assign lit = slot[lit_lsb()];
  assign src = slot[src_lsb() +: BUSW];
  assign dst = slot[dst_lsb(BUSW) +: BUSW];
  assign op  = slot[op_lsb(BUSW) +: OPW];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: snapshots a packed program and issues one instruction per
// valid/ready handshake. Optional stall watchdog: define INSTR_SEQ_WATCHDOG_EN.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int BUSW        = 32,
  parameter int OPW         = 4,
  parameter int PROGLEN     = 8,
  parameter int PLLEN       = OPW + 2 * BUSW + 1,
  parameter int PCW         = $clog2(PROGLEN + 1),
  parameter int WDOG_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PLLEN*PROGLEN-1:0] program_in,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [OPW-1:0]           instr_op,
  output logic [BUSW-1:0]          instr_dst,
  output logic [BUSW-1:0]          instr_src,
  output logic                     instr_lit,
  output logic [PCW-1:0]           instr_pc,
  input  logic                     br_valid,
  input  logic                     br_taken,
  input  logic [PCW-1:0]           br_target,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err
);

  typedef enum logic [1:0] {IDLE, ISSUE, BR_WAIT, HALTED} state_e;

  state_e                   state_q, state_d;
  logic [PCW-1:0]           pc_q, pc_d, pc_inc;
  logic                     done_q, done_d;
  err_e                     err_q, err_d;
  logic                     load;
  logic                     last_slot;
  logic [PLLEN*PROGLEN-1:0] image_q;

  assign pc_inc    = pc_q + PCW'(1);
  assign last_slot = (pc_inc == PCW'(PROGLEN));

`ifdef INSTR_SEQ_WATCHDOG_EN
  localparam int SW = $clog2(WDOG_CYCLES + 1);
  logic [SW-1:0] stall_q;
  logic          wdog_trip;

  assign wdog_trip = (state_q == ISSUE) && !instr_ready && (stall_q == SW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   stall_q <= '0;
    else if ((state_q == ISSUE) && !instr_ready) stall_q <= stall_q + SW'(1);
    else                                       stall_q <= '0;
  end
`else
  logic wdog_trip;
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    done_d      = done_q;
    err_d       = err_q;
    load        = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          load    = 1'b1;
          pc_d    = '0;
          done_d  = 1'b0;
          err_d   = ERR_NONE;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          if (instr_op == OPW'(OP_HLT)) begin
            state_d = HALTED;
            done_d  = 1'b1;
          end else if (instr_op == OPW'(OP_BRA)) begin
            state_d = BR_WAIT;
          end else if (last_slot) begin
            state_d = HALTED;
            done_d  = 1'b1;
            err_d   = ERR_OVERRUN;
          end else begin
            pc_d = pc_inc;
          end
        end else if (wdog_trip) begin
          state_d = HALTED;
          done_d  = 1'b1;
          err_d   = ERR_WATCHDOG;
        end
      end
      BR_WAIT: begin
        if (br_valid) begin
          if (!br_taken) begin
            if (last_slot) begin
              state_d = HALTED;
              done_d  = 1'b1;
              err_d   = ERR_OVERRUN;
            end else begin
              pc_d    = pc_inc;
              state_d = ISSUE;
            end
          end else if (br_target >= PCW'(PROGLEN)) begin
            state_d = HALTED;
            done_d  = 1'b1;
            err_d   = ERR_BAD_TARGET;
          end else begin
            pc_d    = br_target;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the snapshot is a flop bank, not a RAM, and is reset so decoded fields read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       image_q <= '0;
    else if (load) image_q <= program_in;
  end

  instr_slot_decode #(
    .BUSW(BUSW), .OPW(OPW), .PROGLEN(PROGLEN), .PLLEN(PLLEN), .PCW(PCW)
  ) u_decode (
    .image (image_q),
    .pc    (pc_q),
    .op    (instr_op),
    .dst   (instr_dst),
    .src   (instr_src),
    .lit   (instr_lit)
  );

  assign instr_pc = pc_q;
  assign busy     = (state_q == ISSUE) || (state_q == BR_WAIT);
  assign done     = done_q;
  assign err      = err_q;

endmodule
